// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_t      : converter FSM state encoding
//   BCD_MAX      : largest legal BCD digit value
//   ADJ_THRESH   : digit value at or above which the reverse-dabble correction applies
//   ADJ_VAL      : correction subtracted from a digit after each right shift
//   digit_invalid: flags a 4-bit digit that is not legal BCD
package bcd_to_binary_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit correction step of the reverse double-dabble algorithm.
// After the working register is shifted right, a digit that received the
// shifted-in "ten" (now worth 8) must be reduced by 3 so it reads as 5.
// Ports:
//   i_digit  in   4  digit taken from the shifted working register
//   o_digit  out  4  corrected digit (i_digit >= 8 ? i_digit - 3 : i_digit)
module bcd_digit_adjust
    import bcd_to_binary_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADJ_THRESH) begin
            o_digit = i_digit - ADJ_VAL;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble converter: packed BCD in, binary out,
// one result bit resolved per clock with a START/BUSY/DONE handshake.
// Ports:
//   MAX10_CLK1_50  in   1             clock, rising edge
//   RESET_N        in   1             asynchronous active-low reset
//   START          in   1             request conversion (sampled only in idle)
//   BCD_IN         in   4*NUM_DIGITS  packed BCD, [3:0] = least-significant digit
//   BIN_OUT        out  BIN_WIDTH     result, held until the next completion
//   BUSY           out  1             conversion in progress (shift or finish)
//   DONE           out  1             one-cycle completion pulse
//   ERR            out  1             last accepted input held a digit > 9
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 14
) (
    input  logic                      MAX10_CLK1_50,
    input  logic                      RESET_N,
    input  logic                      START,
    input  logic [4*NUM_DIGITS-1:0]   BCD_IN,
    output logic [BIN_WIDTH-1:0]      BIN_OUT,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERR
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_WIDTH;
    localparam int unsigned CNT_W  = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);

    state_t              r_state;
    logic [WORK_W-1:0]   r_work;
    logic [CNT_W-1:0]    r_count;
    logic [BIN_WIDTH-1:0] r_bin;
    logic                r_err;

    state_t              w_state_next;
    logic [WORK_W-1:0]   w_work_next;
    logic [CNT_W-1:0]    w_count_next;
    logic [BIN_WIDTH-1:0] w_bin_next;
    logic                w_err_next;

    logic [WORK_W-1:0]   w_shifted;
    logic [WORK_W-1:0]   w_adjusted;
    logic                w_bcd_invalid;

    // Working register layout: {BCD field, binary field}. Each shift moves the
    // low BCD bit into the binary field MSB; after BIN_WIDTH shifts the binary
    // field holds the full result.
    assign w_shifted                  = r_work >> 1;
    assign w_adjusted[BIN_WIDTH-1:0]  = w_shifted[BIN_WIDTH-1:0];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (w_shifted[BIN_WIDTH + 4*g +: 4]),
            .o_digit (w_adjusted[BIN_WIDTH + 4*g +: 4])
        );
    end

    always_comb begin
        w_bcd_invalid = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (digit_invalid(BCD_IN[4*i +: 4])) begin
                w_bcd_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_work_next  = r_work;
        w_count_next = r_count;
        w_bin_next   = r_bin;
        w_err_next   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_work_next  = {BCD_IN, {BIN_WIDTH{1'b0}}};
                    w_count_next = '0;
                    if (w_bcd_invalid) begin
                        // Skip conversion entirely; report a zero result.
                        w_err_next   = 1'b1;
                        w_bin_next   = '0;
                        w_state_next = S_FINISH;
                    end else begin
                        w_err_next   = 1'b0;
                        w_state_next = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_work_next  = w_adjusted;
                w_count_next = r_count + 1'b1;
                if (r_count == CNT_LAST) begin
                    w_bin_next   = w_adjusted[BIN_WIDTH-1:0];
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_count <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            r_count <= w_count_next;
            r_bin   <= w_bin_next;
            r_err   <= w_err_next;
        end
    end

    assign BIN_OUT = r_bin;
    assign ERR     = r_err;
    assign BUSY    = (r_state != S_IDLE);
    assign DONE    = (r_state == S_FINISH);

endmodule
